hazard_ctrl: RTL and testbench

Pipeline hazard and stall sequencer for the 5-stage pipelined processor. It sits beside the decode stage and drives the write enables, bubble select and flush lines of PC, IF/ID, ID/EX, EX/MEM and MEM/WB from one place. It arbitrates three stall/flush sources:
- multi-cycle data-memory wait (req/ack handshake with timeout),
- taken-branch flush,
- load-use stall.

---
 rtl/hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard/stall sequencer: arbitrates memory wait (with timeout), branch flush and load-use stall.
// Optional build macro HAZARD_PERF_EN adds saturating 32-bit performance counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ID_EX_MemRead,
  input  logic [4:0] ID_EX_RegisterRd,
  input  logic [4:0] IF_ID_RegisterRs1,
  input  logic [4:0] IF_ID_RegisterRs2,
  input  logic       branch_taken,
  input  logic       mem_req,
  input  logic       mem_ack,
  output logic       PC_Write,
  output logic       IFID_Write,
  output logic       IDEX_Write,
  output logic       EXMEM_Write,
  output logic       MEMWB_Write,
  output logic       MUX_Write,
  output logic       IFID_Flush,
  output logic       IDEX_Flush,
  output logic       halted
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] loaduse_stalls,
  output logic [31:0] flush_count
`endif
);

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_ERR} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;

  logic load_use;
  logic mem_stall;
  logic sel_stall, sel_branch, sel_loaduse;

  assign load_use  = ID_EX_MemRead && (ID_EX_RegisterRd != 5'd0) &&
                     ((ID_EX_RegisterRd == IF_ID_RegisterRs1) ||
                      (ID_EX_RegisterRd == IF_ID_RegisterRs2));
  assign mem_stall = mem_req && !mem_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        wait_cnt_d = 8'd0;
        if (mem_stall) begin
          state_d    = ST_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end else if (!mem_req) begin
          // Request withdrawn before completion: protocol violation.
          state_d = ST_ERR;
        end else if (wait_cnt_q >= WAIT_LAST) begin
          state_d = ST_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: begin
        state_d    = ST_ERR;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  always_comb begin
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IDEX_Write  = 1'b1;
    EXMEM_Write = 1'b1;
    MEMWB_Write = 1'b1;
    MUX_Write   = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    halted      = 1'b0;
    sel_stall   = 1'b0;
    sel_branch  = 1'b0;
    sel_loaduse = 1'b0;
    if (state_q == ST_ERR) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Write  = 1'b0;
      EXMEM_Write = 1'b0;
      MEMWB_Write = 1'b0;
      MUX_Write   = 1'b0;
      halted      = 1'b1;
    end else if (mem_stall) begin
      // Full freeze; branch and load-use re-evaluate once registers move again.
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Write  = 1'b0;
      EXMEM_Write = 1'b0;
      MEMWB_Write = 1'b0;
      sel_stall   = 1'b1;
    end else if (branch_taken) begin
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
      sel_branch = 1'b1;
    end else if (load_use) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      MUX_Write   = 1'b0;
      sel_loaduse = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    if (en && (v != 32'hFFFF_FFFF)) return v + 32'd1;
    return v;
  endfunction

  logic [31:0] stall_cycles_q, loaduse_stalls_q, flush_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q   <= 32'd0;
      loaduse_stalls_q <= 32'd0;
      flush_count_q    <= 32'd0;
    end else begin
      stall_cycles_q   <= sat_inc(stall_cycles_q, sel_stall);
      loaduse_stalls_q <= sat_inc(loaduse_stalls_q, sel_loaduse);
      flush_count_q    <= sat_inc(flush_count_q, sel_branch);
    end
  end

  assign stall_cycles   = stall_cycles_q;
  assign loaduse_stalls = loaduse_stalls_q;
  assign flush_count    = flush_count_q;
`else
  logic unused_sel;
  assign unused_sel = sel_stall ^ sel_branch ^ sel_loaduse;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MEM_TIMEOUT = 4) with an expected-output scoreboard.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       ID_EX_MemRead;
  logic [4:0] ID_EX_RegisterRd, IF_ID_RegisterRs1, IF_ID_RegisterRs2;
  logic       branch_taken, mem_req, mem_ack;
  logic       PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write;
  logic       MUX_Write, IFID_Flush, IDEX_Flush, halted;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, loaduse_stalls, flush_count;
`endif

  hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegisterRd(ID_EX_RegisterRd),
    .IF_ID_RegisterRs1(IF_ID_RegisterRs1), .IF_ID_RegisterRs2(IF_ID_RegisterRs2),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IDEX_Write(IDEX_Write),
    .EXMEM_Write(EXMEM_Write), .MEMWB_Write(MEMWB_Write), .MUX_Write(MUX_Write),
    .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush), .halted(halted)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_cycles), .loaduse_stalls(loaduse_stalls), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  // {PC, IFID, IDEX, EXMEM, MEMWB, MUX, IFID_Flush, IDEX_Flush, halted}
  localparam logic [8:0] RUNV = 9'b11111_1_00_0;
  localparam logic [8:0] FRZ  = 9'b00000_1_00_0;
  localparam logic [8:0] BR   = 9'b11111_1_11_0;
  localparam logic [8:0] LU   = 9'b00111_0_00_0;
  localparam logic [8:0] ERRV = 9'b00000_0_00_1;

  logic [8:0] exp_q[$];
  string      tag_q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;

  task automatic step(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic br, input logic req,
                      input logic ack, input logic [8:0] exp, input string tag);
    logic [8:0] obs, e;
    string      t;
    ID_EX_MemRead     = mr;
    ID_EX_RegisterRd  = rd;
    IF_ID_RegisterRs1 = rs1;
    IF_ID_RegisterRs2 = rs2;
    branch_taken      = br;
    mem_req           = req;
    mem_ack           = ack;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #2;
    obs = {PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write,
           MUX_Write, IFID_Flush, IDEX_Flush, halted};
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_cmp++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", t, obs, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [8:0] exp, input string tag);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, exp, tag);
  endtask

  task automatic pulse_reset();
    ID_EX_MemRead = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

`ifdef HAZARD_PERF_EN
  task automatic check_cnt(input logic [31:0] obs, input logic [31:0] e, input string tag);
    n_cmp++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    ID_EX_MemRead = 1'b0; ID_EX_RegisterRd = '0; IF_ID_RegisterRs1 = '0;
    IF_ID_RegisterRs2 = '0; branch_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    idle(RUNV, "reset_idle");
`ifdef HAZARD_PERF_EN
    check_cnt(stall_cycles, 32'd0, "perf_reset");
`endif

    // Load-use on Rs1 and Rs2, x0 exemption, non-load match
    step(1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0, LU,   "lu_rs1");
    step(1'b0, 5'd0, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0, RUNV, "lu_release");
    step(1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, LU,   "lu_rs2");
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, RUNV, "lu_x0");
    step(1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, RUNV, "no_load");

    // Branch wins over load-use
    step(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, BR,   "br_over_lu");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, BR,   "br_only");

    // Three-cycle memory wait then ack
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ,  "mw_frz1");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ,  "mw_frz2");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ,  "mw_frz3");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, RUNV, "mw_ack");
`ifdef HAZARD_PERF_EN
    check_cnt(stall_cycles,   32'd3, "perf_stall");
    check_cnt(loaduse_stalls, 32'd2, "perf_loaduse");
    check_cnt(flush_count,    32'd2, "perf_flush");
`endif
    idle(RUNV, "mw_after");

    // Single-cycle access and stray ack in RUN must not enter WAIT
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, RUNV, "single_acc");
    idle(RUNV, "single_after1");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, RUNV, "stray_ack");
    idle(RUNV, "single_after2");

    // Branch during freeze is held off until the ack cycle
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, FRZ,  "br_frz1");
    step(1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0, FRZ,  "br_frz2");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, BR,   "br_ack");
    idle(RUNV, "br_after");

    // Load-use decoded on the ack cycle
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ,  "lu_frz");
    step(1'b1, 5'd4, 5'd0, 5'd4, 1'b0, 1'b1, 1'b1, LU,   "lu_ack");

    // Protocol violation: request dropped in WAIT without ack
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ,  "pv_frz");
    idle(RUNV, "pv_drop");
    idle(ERRV, "pv_halt");
    step(1'b1, 5'd2, 5'd2, 5'd0, 1'b1, 1'b1, 1'b1, ERRV, "pv_ignore");
    pulse_reset();
    idle(RUNV, "pv_reset");

    // Timeout at MEM_TIMEOUT = 4
    for (int i = 0; i < 4; i++)
      step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ, $sformatf("to_frz%0d", i + 1));
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, ERRV, "to_halt");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, ERRV, "to_ack_late");
    idle(ERRV, "to_sticky");
    pulse_reset();
    idle(RUNV, "to_reset");

    // Three stalls then ack is below the timeout
    for (int i = 0; i < 3; i++)
      step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ, $sformatf("nt_frz%0d", i + 1));
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, RUNV, "nt_ack");

    // Reset mid-WAIT returns to RUN with counter cleared
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ,  "rw_frz");
    pulse_reset();
    idle(RUNV, "rw_reset1");
    idle(RUNV, "rw_reset2");
    for (int i = 0; i < 3; i++)
      step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ, $sformatf("rw_frz%0d", i + 1));
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, RUNV, "rw_ack");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
